// File: rtl/cx_issue.sv
// cx_issue: core-side initiator issuing one custom instruction to a CX unit with bounded wait and registered response
module cx_issue #(
    parameter int TIMEOUT = 16,
    localparam int CNT_W = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_opcode,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic [9:0]  cx_opcode,
    output logic [31:0] cx_op_a,
    output logic [31:0] cx_op_b,
    input  logic [31:0] cx_result,
    input  logic        cx_result_valid,
    input  logic        cx_result_error,
    input  logic        cx_invalid_opcode,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic [1:0]  rsp_status,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [9:0]       op_q;
    logic [31:0]      a_q, b_q, data_q;
    logic [4:0]       rd_q;
    logic [1:0]       status_q;
    logic [CNT_W-1:0] cnt;
    logic             last;
    assign last = cnt == CNT_W'(TIMEOUT - 1);
    always_comb begin
        state_nx = state;
        if (state == IDLE && req_valid)
            state_nx = WAIT;
        else if (state == WAIT && (cx_result_valid || last))
            state_nx = RESP;
        else if (state == RESP && rsp_ready)
            state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            cnt      <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                op_q <= req_opcode;
                a_q  <= req_rs1;
                b_q  <= req_rs2;
                rd_q <= req_rd;
                cnt  <= '0;
            end
            if (state == WAIT) begin
                if (cx_result_valid) begin
                    status_q <= cx_invalid_opcode ? 2'b10 : cx_result_error ? 2'b01 : 2'b00;
                    data_q   <= cx_invalid_opcode ? '0 : cx_result;
                end else if (last) begin
                    status_q <= 2'b11;
                    data_q   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
    assign req_ready  = state == IDLE;
    assign busy       = state != IDLE;
    assign rsp_valid  = state == RESP;
    assign cx_opcode  = (state == WAIT) ? op_q : '0;
    assign cx_op_a    = (state == WAIT) ? a_q : '0;
    assign cx_op_b    = (state == WAIT) ? b_q : '0;
    assign rsp_data   = data_q;
    assign rsp_rd     = rd_q;
    assign rsp_status = status_q;
endmodule
